// File: rtl/tty_engine.sv
// tty_engine: byte-stream terminal controller.
// Decodes control codes, tracks the cursor and drives a single-port VRAM
// bus, with built-in scroll (copy rows up, blank last row) and clear engines.
module tty_engine #(
    parameter int          COLS     = 60,
    parameter int          ROWS     = 17,
    parameter int          COL_W    = 6,
    parameter int          ROW_W    = 5,
    parameter int          TAB      = 8,
    parameter logic [7:0]  FILL     = 8'h20,
    parameter logic [7:0]  ADDR_OFS = 8'h20
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_char,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_autowrap,
    output logic [ROW_W+COL_W-1:0] o_vram_addr,
    output logic [7:0]             o_vram_din,
    input  logic [7:0]             i_vram_dout,
    output logic                   o_vram_ce,
    output logic                   o_vram_w,
    output logic [ROW_W-1:0]       o_cur_row,
    output logic [COL_W-1:0]       o_cur_col,
    output logic                   o_busy
);

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        WRITE,
        SCROLL_RD,
        SCROLL_WR,
        BLANK,
        CLEAR,
        WAIT_ROW,
        WAIT_COL
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t           r_state;
    logic [7:0]       r_char;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_eng_row;
    logic [COL_W-1:0] r_eng_col;

    state_t           w_state_next;
    logic [7:0]       w_char_next;
    logic [ROW_W-1:0] w_row_next;
    logic [COL_W-1:0] w_col_next;
    logic [ROW_W-1:0] w_eng_row_next;
    logic [COL_W-1:0] w_eng_col_next;

    // Next tab stop, one bit wider so an overshoot past the grid is visible.
    logic [COL_W:0]   w_ht_sum;
    logic [COL_W:0]   w_ht_stop;
    // Coordinate byte with the addressing offset removed (8-bit wrap).
    logic [7:0]       w_coord;
    // Destination row of a scroll copy.
    logic [ROW_W-1:0] w_eng_row_m1;

    assign w_ht_sum     = {1'b0, r_col} + (COL_W+1)'(TAB);
    assign w_ht_stop    = w_ht_sum & ~((COL_W+1)'(TAB - 1));
    assign w_coord      = i_char - ADDR_OFS;
    assign w_eng_row_m1 = r_eng_row - ROW_W'(1);

    assign o_cur_row = r_row;
    assign o_cur_col = r_col;

    // State, latched byte, cursor and engine counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_char    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_eng_row <= '0;
            r_eng_col <= '0;
        end else begin
            r_state   <= w_state_next;
            r_char    <= w_char_next;
            r_row     <= w_row_next;
            r_col     <= w_col_next;
            r_eng_row <= w_eng_row_next;
            r_eng_col <= w_eng_col_next;
        end
    end

    // Next-state, cursor/engine updates and VRAM bus drive.
    always_comb begin
        w_state_next   = r_state;
        w_char_next    = r_char;
        w_row_next     = r_row;
        w_col_next     = r_col;
        w_eng_row_next = r_eng_row;
        w_eng_col_next = r_eng_col;
        o_ready        = 1'b0;
        o_vram_ce      = 1'b0;
        o_vram_w       = 1'b0;
        o_vram_addr    = '0;
        o_vram_din     = '0;
        o_busy         = 1'b0;

        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_char_next  = i_char;
                    w_state_next = DECODE;
                end
            end

            DECODE: begin
                w_state_next = IDLE;
                case (r_char)
                    8'h00, 8'h07: ;
                    8'h08, 8'h7F: begin
                        if (r_col != '0) w_col_next = r_col - COL_W'(1);
                    end
                    8'h09: begin
                        if (w_ht_stop <= {1'b0, LAST_COL}) w_col_next = w_ht_stop[COL_W-1:0];
                    end
                    8'h0B: begin
                        if (r_row != '0) w_row_next = r_row - ROW_W'(1);
                    end
                    8'h0D: w_col_next = '0;
                    8'h0A: begin
                        if (r_row < LAST_ROW) begin
                            w_row_next = r_row + ROW_W'(1);
                        end else begin
                            w_state_next   = SCROLL_RD;
                            w_eng_row_next = ROW_W'(1);
                            w_eng_col_next = '0;
                        end
                    end
                    8'h0C: begin
                        w_row_next     = '0;
                        w_col_next     = '0;
                        w_eng_row_next = '0;
                        w_eng_col_next = '0;
                        w_state_next   = CLEAR;
                    end
                    8'h14: w_state_next = WAIT_ROW;
                    default: w_state_next = WRITE;
                endcase
            end

            WRITE: begin
                o_vram_ce    = 1'b1;
                o_vram_w     = 1'b1;
                o_vram_addr  = {r_row, r_col};
                o_vram_din   = r_char;
                w_state_next = IDLE;
                if (r_col < LAST_COL) begin
                    w_col_next = r_col + COL_W'(1);
                end else if (i_autowrap) begin
                    w_col_next = '0;
                    if (r_row < LAST_ROW) begin
                        w_row_next = r_row + ROW_W'(1);
                    end else begin
                        w_state_next   = SCROLL_RD;
                        w_eng_row_next = ROW_W'(1);
                        w_eng_col_next = '0;
                    end
                end
            end

            SCROLL_RD: begin
                o_busy       = 1'b1;
                o_vram_ce    = 1'b1;
                o_vram_addr  = {r_eng_row, r_eng_col};
                w_state_next = SCROLL_WR;
            end

            SCROLL_WR: begin
                o_busy      = 1'b1;
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {w_eng_row_m1, r_eng_col};
                o_vram_din  = i_vram_dout;
                if (r_eng_col == LAST_COL) begin
                    w_eng_col_next = '0;
                    if (r_eng_row == LAST_ROW) begin
                        w_state_next = BLANK;
                    end else begin
                        w_eng_row_next = r_eng_row + ROW_W'(1);
                        w_state_next   = SCROLL_RD;
                    end
                end else begin
                    w_eng_col_next = r_eng_col + COL_W'(1);
                    w_state_next   = SCROLL_RD;
                end
            end

            BLANK: begin
                o_busy      = 1'b1;
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {LAST_ROW, r_eng_col};
                o_vram_din  = FILL;
                if (r_eng_col == LAST_COL) begin
                    w_eng_col_next = '0;
                    w_state_next   = IDLE;
                end else begin
                    w_eng_col_next = r_eng_col + COL_W'(1);
                end
            end

            CLEAR: begin
                o_busy      = 1'b1;
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {r_eng_row, r_eng_col};
                o_vram_din  = FILL;
                if (r_eng_col == LAST_COL) begin
                    w_eng_col_next = '0;
                    if (r_eng_row == LAST_ROW) begin
                        w_eng_row_next = '0;
                        w_state_next   = IDLE;
                    end else begin
                        w_eng_row_next = r_eng_row + ROW_W'(1);
                    end
                end else begin
                    w_eng_col_next = r_eng_col + COL_W'(1);
                end
            end

            WAIT_ROW: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (w_coord > 8'(ROWS - 1)) w_row_next = LAST_ROW;
                    else                        w_row_next = ROW_W'(w_coord);
                    w_state_next = WAIT_COL;
                end
            end

            WAIT_COL: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (w_coord > 8'(COLS - 1)) w_col_next = LAST_COL;
                    else                        w_col_next = COL_W'(w_coord);
                    w_state_next = IDLE;
                end
            end

            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tty_engine.sv
// tb_tty_engine: directed stimulus against a screen/cursor model of the
// terminal, with a VRAM memory and a per-access bus checker.
module tb_tty_engine;

    localparam int         COLS  = 60;
    localparam int         ROWS  = 17;
    localparam int         COL_W = 6;
    localparam int         ROW_W = 5;
    localparam int         TAB   = 8;
    localparam int         AW    = ROW_W + COL_W;
    localparam logic [7:0] FILL  = 8'h20;
    localparam logic [7:0] OFS   = 8'h20;
    localparam int         LIMIT = 5000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       i_char = 8'h00;
    logic             i_valid = 1'b0;
    logic             i_autowrap = 1'b1;
    logic             o_ready;
    logic [AW-1:0]    o_vram_addr;
    logic [7:0]       o_vram_din;
    logic [7:0]       vram_dout = 8'h00;
    logic             o_vram_ce;
    logic             o_vram_w;
    logic [ROW_W-1:0] o_cur_row;
    logic [COL_W-1:0] o_cur_col;
    logic             o_busy;

    tty_engine dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_char      (i_char),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_autowrap  (i_autowrap),
        .o_vram_addr (o_vram_addr),
        .o_vram_din  (o_vram_din),
        .i_vram_dout (vram_dout),
        .o_vram_ce   (o_vram_ce),
        .o_vram_w    (o_vram_w),
        .o_cur_row   (o_cur_row),
        .o_cur_col   (o_cur_col),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          w;
        logic [7:0]    din;
    } acc_t;

    acc_t       exp_q[$];
    acc_t       e;
    logic [7:0] vram [0:(1<<AW)-1];
    logic [7:0] scr      [0:ROWS-1][0:COLS-1];
    logic [7:0] scr_save [0:ROWS-1][0:COLS-1];
    logic [7:0] row1_old [0:COLS-1];
    int         mr = 0, mc = 0, mode = 0;
    int         n_vec = 0, n_fail = 0, busy_ce = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [7:0]    last_wr_din = '0;

    // Synchronous single-port VRAM: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (o_vram_ce) begin
            if (o_vram_w) vram[o_vram_addr] <= o_vram_din;
            else          vram_dout <= vram[o_vram_addr];
        end
    end

    function automatic logic [AW-1:0] adr(input int r, input int c);
        adr = AW'((r << COL_W) + c);
    endfunction

    task automatic push_acc(input int r, input int c, input logic w, input logic [7:0] d);
        acc_t a;
        a.addr = adr(r, c);
        a.w    = w;
        a.din  = d;
        exp_q.push_back(a);
    endtask

    task automatic model_scroll();
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                push_acc(r, c, 1'b0, 8'h00);
                push_acc(r - 1, c, 1'b1, scr[r][c]);
                scr[r-1][c] = scr[r][c];
            end
        for (int c = 0; c < COLS; c++) begin
            push_acc(ROWS - 1, c, 1'b1, FILL);
            scr[ROWS-1][c] = FILL;
        end
    endtask

    // Terminal semantics applied to one accepted byte.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] v;
        int t;
        v = b - OFS;
        if (mode == 1) begin
            mr = (int'(v) > ROWS - 1) ? ROWS - 1 : int'(v);
            mode = 2;
        end else if (mode == 2) begin
            mc = (int'(v) > COLS - 1) ? COLS - 1 : int'(v);
            mode = 0;
        end else begin
            case (b)
                8'h00, 8'h07: ;
                8'h08, 8'h7F: if (mc > 0) mc--;
                8'h09: begin
                    t = (mc / TAB + 1) * TAB;
                    if (t <= COLS - 1) mc = t;
                end
                8'h0B: if (mr > 0) mr--;
                8'h0D: mc = 0;
                8'h0A: if (mr < ROWS - 1) mr++; else model_scroll();
                8'h0C: begin
                    mr = 0;
                    mc = 0;
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) begin
                            push_acc(r, c, 1'b1, FILL);
                            scr[r][c] = FILL;
                        end
                end
                8'h14: mode = 1;
                default: begin
                    push_acc(mr, mc, 1'b1, b);
                    scr[mr][mc] = b;
                    if (mc < COLS - 1) mc++;
                    else if (i_autowrap) begin
                        mc = 0;
                        if (mr < ROWS - 1) mr++; else model_scroll();
                    end
                end
            endcase
        end
    endtask

    // Every VRAM access is checked against the model's expected sequence.
    always @(negedge clk) begin
        if (!rst && o_vram_ce) begin
            if (o_busy) busy_ce++;
            if (o_vram_w) begin
                last_wr_addr = o_vram_addr;
                last_wr_din  = o_vram_din;
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL vram_access: got addr %h w %b din %h, required no access",
                         o_vram_addr, o_vram_w, o_vram_din);
            end else begin
                e = exp_q.pop_front();
                if (o_vram_addr !== e.addr || o_vram_w !== e.w || (e.w && o_vram_din !== e.din)) begin
                    n_fail++;
                    $display("FAIL vram_access: got addr %h w %b din %h, required addr %h w %b din %h",
                             o_vram_addr, o_vram_w, o_vram_din, e.addr, e.w, e.din);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_screen(input string name);
        int bad;
        for (int r = 0; r < ROWS; r++) begin
            bad = -1;
            for (int c = COLS - 1; c >= 0; c--)
                if (vram[adr(r, c)] !== scr[r][c]) bad = c;
            n_vec++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s row %0d col %0d: got %h, required %h",
                         name, r, bad, vram[adr(r, bad)], scr[r][bad]);
            end
        end
    endtask

    task automatic wait_ready();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!o_ready && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        if (!o_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL ready_timeout: got o_ready 0, required 1 within %0d cycles", LIMIT);
        end
    endtask

    task automatic send(input logic [7:0] b, output int low);
        wait_ready();
        i_char  = b;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        model_byte(b);
        low = 0;
        @(negedge clk);
        while (!o_ready && low < LIMIT) begin
            low++;
            @(negedge clk);
        end
        if (!o_ready) chk("ready_return", {31'b0, o_ready}, 32'd1);
        chk("cursor_row", o_cur_row, mr);
        chk("cursor_col", o_cur_col, mc);
        $display("tx %02h -> cursor (%0d,%0d) ready-low %0d", b, o_cur_row, o_cur_col, low);
    endtask

    task automatic send_list(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int l;
        send(b0, l);
        send(b1, l);
        send(b2, l);
    endtask

    logic [7:0] mixed [0:13] = '{8'h08, 8'h08, 8'h0A, 8'h0A, 8'h42, 8'h0D, 8'h43,
                                 8'h09, 8'h0B, 8'h00, 8'h07, 8'h7F, 8'h7F, 8'h0A};

    initial begin
        int low, cnt, t, bad;
        for (int i = 0; i < (1 << AW); i++) vram[i] = 8'(i * 7 + 3);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = vram[adr(r, c)];

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_ce",    {31'b0, o_vram_ce}, 32'd0);
        chk("rst_w",     {31'b0, o_vram_w}, 32'd0);
        chk("rst_busy",  {31'b0, o_busy}, 32'd0);
        chk("rst_addr",  o_vram_addr, 32'd0);
        chk("rst_din",   o_vram_din, 32'd0);
        chk("rst_row",   o_cur_row, 32'd0);
        chk("rst_col",   o_cur_col, 32'd0);
        rst = 1'b0;

        // Printable at origin
        i_autowrap = 1'b1;
        send(8'h41, low);
        chk("A_ready_low", low, 32'd2);
        chk("A_addr", last_wr_addr, 32'd0);
        chk("A_din", last_wr_din, 32'h41);
        chk("A_row", o_cur_row, 32'd0);
        chk("A_col", o_cur_col, 32'd1);

        // Control code mix
        for (int i = 0; i < 14; i++) send(mixed[i], low);

        // Cursor addressing with clamping
        send_list(8'h14, 8'h25, 8'h7F);
        chk("clamp_row", o_cur_row, 32'd5);
        chk("clamp_col", o_cur_col, 32'd59);

        // Tab stops near the right edge
        send_list(8'h14, 8'h23, 8'h55);
        send(8'h09, low);
        chk("ht1_col", o_cur_col, 32'd56);
        send(8'h09, low);
        chk("ht2_col", o_cur_col, 32'd56);

        // Autowrap at bottom-right scrolls the screen
        send_list(8'h14, 8'h30, 8'h5B);
        for (int c = 0; c < COLS; c++) row1_old[c] = vram[adr(1, c)];
        busy_ce = 0;
        send(8'h5A, low);
        chk("scroll_ce_cycles", busy_ce, 32'd1980);
        chk("scroll_ready_low", low, 32'd1982);
        chk("scroll_row", o_cur_row, 32'd16);
        chk("scroll_col", o_cur_col, 32'd0);
        bad = 0;
        for (int c = 0; c < COLS; c++) if (vram[adr(0, c)] !== row1_old[c]) bad++;
        chk("row0_old_row1", bad, 32'd0);
        bad = 0;
        for (int c = 0; c < COLS; c++) if (vram[adr(16, c)] !== 8'h20) bad++;
        chk("row16_blank", bad, 32'd0);
        chk("scroll_z_moved", vram[adr(15, 59)], 32'h5A);
        chk("scroll_queue", exp_q.size(), 32'd0);
        check_screen("scroll_screen");

        // Sticky last column without autowrap
        i_autowrap = 1'b0;
        send_list(8'h14, 8'h30, 8'h5B);
        send(8'h5A, low);
        send(8'h59, low);
        chk("sticky_row", o_cur_row, 32'd16);
        chk("sticky_col", o_cur_col, 32'd59);
        chk("sticky_addr", last_wr_addr, 32'd1083);
        chk("sticky_cell", vram[1083], 32'h59);
        chk("sticky_queue", exp_q.size(), 32'd0);
        check_screen("sticky_screen");

        // Clear aborted by reset after 100 cells
        wait_ready();
        i_char  = 8'h0C;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        scr_save = scr;
        model_byte(8'h0C);
        cnt = 0;
        t = 0;
        while (cnt < 100 && t < LIMIT) begin
            @(negedge clk);
            t++;
            if (o_vram_ce) cnt++;
        end
        chk("clear_reach_100", cnt, 32'd100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ce",    {31'b0, o_vram_ce}, 32'd0);
        chk("abort_busy",  {31'b0, o_busy}, 32'd0);
        chk("abort_ready", {31'b0, o_ready}, 32'd1);
        chk("abort_row",   o_cur_row, 32'd0);
        chk("abort_col",   o_cur_col, 32'd0);
        exp_q.delete();
        mr = 0;
        mc = 0;
        mode = 0;
        scr = scr_save;
        for (int k = 0; k < 100; k++) scr[k / COLS][k % COLS] = FILL;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_screen("abort_screen");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
